// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: streams bytes MSB-first on sck/copi under cs,
// captures cipo full-duplex and returns each received byte with a pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   tx_valid_i/ready_o  byte stream in (tx_data_i, tx_last_i ends frame)
//   rx_valid_o/data_o   received byte, one-cycle valid pulse
//   busy_o              high whenever a frame is in progress
//   spi_sck_o/copi_o    SPI clock (idle low) and data to target
//   spi_cs_o            target select, active low
//   spi_cipo_i          SPI data from target
module spi_initiator #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_copi_o,
  output logic       spi_cs_o,
  input  logic       spi_cipo_i
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    WAIT,
    HOLD
  } state_t;

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAXC   = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  // bit 7 goes straight from tx_data_i to copi, so only 6..0 are kept
  logic [6:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          last_q;
  logic          accept;

  assign accept = tx_valid_i & tx_ready_o;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      last_q     <= 1'b0;
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      busy_o     <= 1'b0;
      spi_sck_o  <= 1'b0;
      spi_copi_o <= 1'b0;
      spi_cs_o   <= 1'b1;
    end else begin
      rx_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= SETUP;
            cnt        <= SETUP_LD;
            bit_cnt    <= 3'd7;
            tx_sh      <= tx_data_i[6:0];
            last_q     <= tx_last_i;
            spi_copi_o <= tx_data_i[7];
            spi_cs_o   <= 1'b0;
            tx_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end else begin
            tx_ready_o <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= LOW;
            cnt   <= DIV_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            // capture on the same edge sck rises
            state     <= HIGH;
            cnt       <= DIV_LD;
            spi_sck_o <= 1'b1;
            rx_sh     <= {rx_sh[6:0], spi_cipo_i};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            spi_sck_o <= 1'b0;
            if (bit_cnt != 3'd0) begin
              state      <= LOW;
              cnt        <= DIV_LD;
              bit_cnt    <= bit_cnt - 1'b1;
              spi_copi_o <= tx_sh[6];
              tx_sh      <= {tx_sh[5:0], 1'b0};
            end else begin
              rx_data_o  <= rx_sh;
              rx_valid_o <= 1'b1;
              if (last_q) begin
                state <= HOLD;
                cnt   <= HOLD_LD;
              end else begin
                state      <= WAIT;
                tx_ready_o <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          // CS is already low, so the next byte skips setup
          if (accept) begin
            state      <= LOW;
            cnt        <= DIV_LD;
            bit_cnt    <= 3'd7;
            tx_sh      <= tx_data_i[6:0];
            last_q     <= tx_last_i;
            spi_copi_o <= tx_data_i[7];
            tx_ready_o <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state      <= IDLE;
            spi_cs_o   <= 1'b1;
            spi_copi_o <= 1'b0;
            busy_o     <= 1'b0;
            tx_ready_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_initiator.sv
// Directed testbench for spi_initiator: loopback frames at CLK_DIV=4,
// plus a CLK_DIV=1 instance with cipo held high.
module tb_spi_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid, tx_last, tx_ready, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       sck, copi, cs, cipo;

  logic       tx_valid1, tx_last1, tx_ready1, rx_valid1, busy1;
  logic [7:0] tx_data1, rx_data1;
  logic       sck1, copi1, cs1, cipo1;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  assign cipo  = copi;
  assign cipo1 = 1'b1;

  spi_initiator dut (
    .clk(clk), .reset(reset),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_last_i(tx_last), .tx_ready_o(tx_ready),
    .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .busy_o(busy), .spi_sck_o(sck),
    .spi_copi_o(copi), .spi_cs_o(cs),
    .spi_cipo_i(cipo)
  );

  spi_initiator #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .tx_valid_i(tx_valid1), .tx_data_i(tx_data1),
    .tx_last_i(tx_last1), .tx_ready_o(tx_ready1),
    .rx_valid_o(rx_valid1), .rx_data_o(rx_data1),
    .busy_o(busy1), .spi_sck_o(sck1),
    .spi_copi_o(copi1), .spi_cs_o(cs1),
    .spi_cipo_i(cipo1)
  );

  // waveform monitor for the main instance
  int          cs_low_n = 0;
  int          cs_rise_n = 0;
  int          rise_n = 0;
  int          rxv_n = 0;
  logic [31:0] copi_hist = '0;
  logic [15:0] rx_hist = '0;
  logic        sck_q = 1'b0;
  logic        cs_q = 1'b1;

  always @(negedge clk) begin
    if (cs === 1'b0) cs_low_n++;
    if (cs === 1'b1 && cs_q === 1'b0) cs_rise_n++;
    if (sck === 1'b1 && sck_q === 1'b0) begin
      rise_n++;
      copi_hist = {copi_hist[30:0], copi};
    end
    if (rx_valid === 1'b1) begin
      rxv_n++;
      rx_hist = {rx_hist[7:0], rx_data};
    end
    sck_q = sck;
    cs_q  = cs;
  end

  task automatic offer(input logic [7:0] d, input logic l,
                       input bit hold, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      to = 1'b1;
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #1;
    to = (busy !== 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({cs, sck, copi} !== 3'b100) begin
      err++;
      $display("FAIL rst_pins got %b want 100", {cs, sck, copi});
    end
    vec++;
    if ({rx_valid, busy, tx_ready} !== 3'b000) begin
      err++;
      $display("FAIL rst_flags got %b want 000",
               {rx_valid, busy, tx_ready});
    end
    vec++;
    if (rx_data !== 8'h00) begin
      err++;
      $display("FAIL rst_rx got %h want 00", rx_data);
    end
    vec++;
    if ({cs1, tx_ready1} !== 2'b10) begin
      err++;
      $display("FAIL rst_dut1 got %b want 10", {cs1, tx_ready1});
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if ({tx_ready, busy, cs} !== 3'b101) begin
      err++;
      $display("FAIL rel_ready got %b want 101", {tx_ready, busy, cs});
    end
    vec++;
    if (tx_ready1 !== 1'b1) begin
      err++;
      $display("FAIL rel_ready1 got %b want 1", tx_ready1);
    end
  endtask

  task automatic test_single_byte;
    int b_cs, b_r, b_v;
    bit to;
    b_cs = cs_low_n; b_r = rise_n; b_v = rxv_n;
    offer(8'hA5, 1'b1, 1'b0, to);
    vec++;
    if (to) begin err++; $display("FAIL a5_accept got timeout want accept"); end
    wait_idle(to);
    vec++;
    if (to) begin err++; $display("FAIL a5_idle got timeout want idle"); end
    vec++;
    if (rise_n - b_r != 8) begin
      err++;
      $display("FAIL a5_rises got %0d want 8", rise_n - b_r);
    end
    vec++;
    if (copi_hist[7:0] !== 8'hA5) begin
      err++;
      $display("FAIL a5_copi got %h want a5", copi_hist[7:0]);
    end
    vec++;
    if (rxv_n - b_v != 1 || rx_hist[7:0] !== 8'hA5) begin
      err++;
      $display("FAIL a5_rxv got %0d/%h want 1/a5",
               rxv_n - b_v, rx_hist[7:0]);
    end
    vec++;
    if (rx_data !== 8'hA5) begin
      err++;
      $display("FAIL a5_rxdata got %h want a5", rx_data);
    end
    vec++;
    if (cs_low_n - b_cs != 68) begin
      err++;
      $display("FAIL a5_cslow got %0d want 68", cs_low_n - b_cs);
    end
    vec++;
    if ({cs, sck, copi} !== 3'b100) begin
      err++;
      $display("FAIL a5_end got %b want 100", {cs, sck, copi});
    end
  endtask

  task automatic test_back_to_back;
    int b_cs, b_r, b_v, b_cr;
    bit to, to2, to3;
    b_cs = cs_low_n; b_r = rise_n; b_v = rxv_n; b_cr = cs_rise_n;
    offer(8'h3C, 1'b0, 1'b1, to);
    offer(8'hC3, 1'b1, 1'b0, to2);
    wait_idle(to3);
    vec++;
    if (to | to2 | to3) begin
      err++;
      $display("FAIL b2b_flow got timeout want done");
    end
    vec++;
    if (rise_n - b_r != 16) begin
      err++;
      $display("FAIL b2b_rises got %0d want 16", rise_n - b_r);
    end
    vec++;
    if (copi_hist[15:0] !== 16'h3CC3) begin
      err++;
      $display("FAIL b2b_copi got %h want 3cc3", copi_hist[15:0]);
    end
    vec++;
    if (rxv_n - b_v != 2 || rx_hist !== 16'h3CC3) begin
      err++;
      $display("FAIL b2b_rx got %0d/%h want 2/3cc3",
               rxv_n - b_v, rx_hist);
    end
    vec++;
    if (cs_low_n - b_cs != 133 || cs_rise_n - b_cr != 1) begin
      err++;
      $display("FAIL b2b_cs got %0d/%0d want 133/1",
               cs_low_n - b_cs, cs_rise_n - b_cr);
    end
  endtask

  task automatic test_wait;
    int b_cs, b_v, b_cr, n;
    bit to, to2;
    b_cs = cs_low_n; b_v = rxv_n; b_cr = cs_rise_n;
    offer(8'h3C, 1'b0, 1'b0, to);
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (to || tx_ready !== 1'b1) begin
      err++;
      $display("FAIL wait_enter got timeout want wait");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec++;
      if ({sck, cs, tx_ready} !== 3'b001) begin
        err++;
        $display("FAIL wait_hold%0d got %b want 001",
                 i, {sck, cs, tx_ready});
      end
    end
    offer(8'h01, 1'b1, 1'b0, to);
    wait_idle(to2);
    vec++;
    if (to | to2) begin
      err++;
      $display("FAIL wait_done got timeout want done");
    end
    vec++;
    if (rx_data !== 8'h01 || rxv_n - b_v != 2) begin
      err++;
      $display("FAIL wait_rx got %h/%0d want 01/2",
               rx_data, rxv_n - b_v);
    end
    vec++;
    if (cs_low_n - b_cs != 154 || cs_rise_n - b_cr != 1) begin
      err++;
      $display("FAIL wait_cs got %0d/%0d want 154/1",
               cs_low_n - b_cs, cs_rise_n - b_cr);
    end
  endtask

  task automatic test_reset_mid;
    int b_cs, b_r, b_v, n;
    bit to, to2;
    b_r = rise_n; b_v = rxv_n;
    offer(8'hFF, 1'b1, 1'b0, to);
    n = 0;
    while (rise_n - b_r < 3 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    vec++;
    if (to || rise_n - b_r != 3) begin
      err++;
      $display("FAIL mid_rise3 got %0d want 3", rise_n - b_r);
    end
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if ({cs, sck, copi} !== 3'b100) begin
      err++;
      $display("FAIL mid_pins got %b want 100", {cs, sck, copi});
    end
    vec++;
    if ({rx_valid, busy} !== 2'b00 || rx_data !== 8'h00) begin
      err++;
      $display("FAIL mid_flags got %b/%h want 00/00",
               {rx_valid, busy}, rx_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    vec++;
    if (rxv_n - b_v != 0) begin
      err++;
      $display("FAIL mid_norx got %0d want 0", rxv_n - b_v);
    end
    b_cs = cs_low_n; b_r = rise_n; b_v = rxv_n;
    offer(8'h81, 1'b1, 1'b0, to);
    wait_idle(to2);
    vec++;
    if (to | to2) begin
      err++;
      $display("FAIL mid_next got timeout want done");
    end
    vec++;
    if (rise_n - b_r != 8 || copi_hist[7:0] !== 8'h81) begin
      err++;
      $display("FAIL mid_wave got %0d/%h want 8/81",
               rise_n - b_r, copi_hist[7:0]);
    end
    vec++;
    if (rx_data !== 8'h81 || rxv_n - b_v != 1) begin
      err++;
      $display("FAIL mid_rx got %h/%0d want 81/1",
               rx_data, rxv_n - b_v);
    end
    vec++;
    if (cs_low_n - b_cs != 68) begin
      err++;
      $display("FAIL mid_cslow got %0d want 68", cs_low_n - b_cs);
    end
  endtask

  task automatic test_clkdiv1;
    int   csl, rises, rxv, rxk;
    logic sp, e;
    csl = 0; rises = 0; rxv = 0; rxk = 0; sp = 1'b0;
    @(negedge clk);
    vec++;
    if (tx_ready1 !== 1'b1) begin
      err++;
      $display("FAIL d1_ready got %b want 1", tx_ready1);
    end
    tx_valid1 = 1'b1;
    tx_data1  = 8'h00;
    tx_last1  = 1'b1;
    @(posedge clk);
    #1;
    tx_valid1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 10) begin
        vec++;
        if (tx_ready1 !== 1'b0) begin
          err++;
          $display("FAIL d1_shift_ready got %b want 0", tx_ready1);
        end
        tx_valid1 = 1'b1;
        tx_data1  = 8'hFF;
        tx_last1  = 1'b0;
      end
      if (k == 11) tx_valid1 = 1'b0;
      if (cs1 === 1'b0) csl++;
      if (sck1 === 1'b1 && sp === 1'b0) rises++;
      sp = sck1;
      if (rx_valid1 === 1'b1) begin
        rxv++;
        if (rxk == 0) rxk = k;
      end
      if (k >= 3 && k <= 18) begin
        e = ((k - 3) % 2) == 1;
        vec++;
        if ({sck1, copi1} !== {e, 1'b0}) begin
          err++;
          $display("FAIL d1_sck%0d got %b want %b",
                   k, {sck1, copi1}, {e, 1'b0});
        end
      end
    end
    vec++;
    if (rises != 8 || rxk != 19 || rxv != 1) begin
      err++;
      $display("FAIL d1_timing got %0d/%0d/%0d want 8/19/1",
               rises, rxk, rxv);
    end
    vec++;
    if (rx_data1 !== 8'hFF) begin
      err++;
      $display("FAIL d1_rx got %h want ff", rx_data1);
    end
    vec++;
    if (csl != 20) begin
      err++;
      $display("FAIL d1_cslow got %0d want 20", csl);
    end
    vec++;
    if ({busy1, tx_ready1, cs1} !== 3'b011) begin
      err++;
      $display("FAIL d1_end got %b want 011",
               {busy1, tx_ready1, cs1});
    end
  endtask

  initial begin
    reset     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    tx_valid1 = 1'b0;
    tx_data1  = 8'h00;
    tx_last1  = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
